// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 10-stage pipeline.
// Stage order: 0 pc, 1 if, 2 ic, 3 id, 4 ex, 5 dtlb, 6 dt, 7 dcache, 8 mem, 9 wb.
// The deepest active stall requester selects a stall pattern that is
// contiguous from stage 0. Exception/eret redirects become a one-cycle
// flush, which is deferred while a dcache access is outstanding.
// Saturating counters record which stall cause won each cycle.
module pipe_stall_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_icache,
   input  logic             stallreq_for_load,
   input  logic             stallreq_for_ex,
   input  logic             stallreq_dcache,
   input  logic             except_valid,
   input  logic [31:0]      except_target,
   input  logic             perf_clr,
   output logic [9:0]       stall,
   output logic             flush,
   output logic [31:0]      new_pc,
   output logic             ctrl_busy,
   output logic [CNT_W-1:0] cnt_icache,
   output logic [CNT_W-1:0] cnt_load,
   output logic [CNT_W-1:0] cnt_ex,
   output logic [CNT_W-1:0] cnt_dcache
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT_DC = 2'd1;
   localparam logic [1:0] ST_FLUSH   = 2'd2;
   localparam logic [1:0] ST_HOLD    = 2'd3;

   // Index of each cause in the one-hot winner vector and the counter bank.
   localparam int C_ICACHE = 0;
   localparam int C_LOAD   = 1;
   localparam int C_EX     = 2;
   localparam int C_DCACHE = 3;

   logic [1:0]           state_reg;
   logic [1:0]           state_next;
   logic [31:0]          pend_pc_reg;
   logic [31:0]          pend_pc_next;
   logic [3:0]           win;
   logic [9:0]           req_stall;
   logic                 count_en;
   logic [4*CNT_W-1:0]   cnt_flat;

   // Priority select: only the deepest requester's pattern is driven, never an OR.
   always_comb begin
      win       = 4'b0000;
      req_stall = 10'h000;
      if (stallreq_dcache) begin
         win[C_DCACHE] = 1'b1;
         req_stall     = 10'h1FF;
      end else if (stallreq_for_ex) begin
         win[C_EX]     = 1'b1;
         req_stall     = 10'h01F;
      end else if (stallreq_for_load) begin
         win[C_LOAD]   = 1'b1;
         req_stall     = 10'h00F;
      end else if (stallreq_icache) begin
         win[C_ICACHE] = 1'b1;
         req_stall     = 10'h007;
      end
   end

   // Redirect sequencer next-state; a redirect is only accepted in IDLE.
   always_comb begin
      state_next   = state_reg;
      pend_pc_next = pend_pc_reg;
      case (state_reg)
         ST_IDLE: begin
            if (except_valid) begin
               pend_pc_next = except_target;
               state_next   = stallreq_dcache ? ST_WAIT_DC : ST_FLUSH;
            end
         end
         ST_WAIT_DC: begin
            if (!stallreq_dcache) begin
               state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            state_next = ST_HOLD;
         end
         ST_HOLD: begin
            // One dead cycle so a stale except_valid from the next
            // instruction cannot start a second redirect.
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Sequencer state and latched redirect target.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         pend_pc_reg <= 32'h0000_0000;
      end else begin
         state_reg   <= state_next;
         pend_pc_reg <= pend_pc_next;
      end
   end

   // Flush wins over any stall request so the flushed stages really clear.
   assign stall     = (state_reg == ST_FLUSH) ? 10'h000 : req_stall;
   assign flush     = (state_reg == ST_FLUSH);
   assign new_pc    = (state_reg == ST_FLUSH) ? pend_pc_reg : 32'h0000_0000;
   assign ctrl_busy = (state_reg != ST_IDLE);

   // Stall time spent during FLUSH/HOLD is redirect overhead, not a stall cause.
   assign count_en  = (state_reg == ST_IDLE) || (state_reg == ST_WAIT_DC);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;

         // Saturating per-cause counter; clear takes priority over increment.
         always_ff @(posedge clk) begin
            if (rst || perf_clr) begin
               cnt_reg <= '0;
            end else if (count_en && win[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end

         assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
      end
   endgenerate

   assign cnt_icache = cnt_flat[C_ICACHE*CNT_W +: CNT_W];
   assign cnt_load   = cnt_flat[C_LOAD*CNT_W   +: CNT_W];
   assign cnt_ex     = cnt_flat[C_EX*CNT_W     +: CNT_W];
   assign cnt_dcache = cnt_flat[C_DCACHE*CNT_W +: CNT_W];

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed testbench for pipe_stall_ctrl with a 4-bit counter width so that
// saturation is reachable in a few cycles.
module tb_pipe_stall_ctrl;

   localparam int W = 4;

   logic          clk;
   logic          rst;
   logic          stallreq_icache;
   logic          stallreq_for_load;
   logic          stallreq_for_ex;
   logic          stallreq_dcache;
   logic          except_valid;
   logic [31:0]   except_target;
   logic          perf_clr;
   logic [9:0]    stall;
   logic          flush;
   logic [31:0]   new_pc;
   logic          ctrl_busy;
   logic [W-1:0]  cnt_icache;
   logic [W-1:0]  cnt_load;
   logic [W-1:0]  cnt_ex;
   logic [W-1:0]  cnt_dcache;

   int errors = 0;
   int checks = 0;

   pipe_stall_ctrl #(.CNT_W(W)) dut (
      .clk               (clk),
      .rst               (rst),
      .stallreq_icache   (stallreq_icache),
      .stallreq_for_load (stallreq_for_load),
      .stallreq_for_ex   (stallreq_for_ex),
      .stallreq_dcache   (stallreq_dcache),
      .except_valid      (except_valid),
      .except_target     (except_target),
      .perf_clr          (perf_clr),
      .stall             (stall),
      .flush             (flush),
      .new_pc            (new_pc),
      .ctrl_busy         (ctrl_busy),
      .cnt_icache        (cnt_icache),
      .cnt_load          (cnt_load),
      .cnt_ex            (cnt_ex),
      .cnt_dcache        (cnt_dcache)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic ic, input logic ld, input logic ex, input logic dc);
      stallreq_icache   = ic;
      stallreq_for_load = ld;
      stallreq_for_ex   = ex;
      stallreq_dcache   = dc;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_req(0, 0, 0, 0);
      except_valid = 1'b0;
      except_target = 32'h0;
      perf_clr = 1'b0;
      repeat (2) tick();
      checks++; if (stall !== 10'h000) begin errors++; $display("FAIL reset_stall got=%h exp=000", stall); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
      checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
      checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", ctrl_busy); end
      checks++; if ({cnt_icache, cnt_load, cnt_ex, cnt_dcache} !== 16'h0) begin errors++; $display("FAIL reset_cnts got=%h exp=0000", {cnt_icache, cnt_load, cnt_ex, cnt_dcache}); end
      rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_stall_patterns();
      logic [3:0]  vec_req [8];   // {ic, ld, ex, dc}
      logic [9:0]  vec_exp [8];
      vec_req[0] = 4'b0100; vec_exp[0] = 10'h00F;
      vec_req[1] = 4'b0100; vec_exp[1] = 10'h00F;
      vec_req[2] = 4'b0100; vec_exp[2] = 10'h00F;
      vec_req[3] = 4'b1100; vec_exp[3] = 10'h00F;
      vec_req[4] = 4'b0110; vec_exp[4] = 10'h01F;
      vec_req[5] = 4'b1111; vec_exp[5] = 10'h1FF;
      vec_req[6] = 4'b1000; vec_exp[6] = 10'h007;
      vec_req[7] = 4'b0000; vec_exp[7] = 10'h000;
      for (int i = 0; i < 8; i++) begin
         tick();
         set_req(vec_req[i][3], vec_req[i][2], vec_req[i][1], vec_req[i][0]);
         #1;
         checks++; if (stall !== vec_exp[i]) begin errors++; $display("FAIL stall_vec%0d req=%b got=%h exp=%h", i, vec_req[i], stall, vec_exp[i]); end
      end
      tick();
      // load-only x3 plus load+icache -> 4; ex, dcache and icache won once each.
      checks++; if (cnt_load !== 4'd4) begin errors++; $display("FAIL cnt_load got=%0d exp=4", cnt_load); end
      checks++; if (cnt_ex !== 4'd1) begin errors++; $display("FAIL cnt_ex_once got=%0d exp=1", cnt_ex); end
      checks++; if (cnt_dcache !== 4'd1) begin errors++; $display("FAIL cnt_dcache_once got=%0d exp=1", cnt_dcache); end
      checks++; if (cnt_icache !== 4'd1) begin errors++; $display("FAIL cnt_icache_once got=%0d exp=1", cnt_icache); end
      $display("test_stall_patterns done");
   endtask

   task automatic test_flush();
      tick();
      except_valid = 1'b1; except_target = 32'hBFC0_0380;
      #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_early got=%b exp=0", flush); end
      tick();
      except_valid = 1'b1; except_target = 32'h1234_5678;   // must be ignored
      #1;
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL flush_pulse got=%b exp=1", flush); end
      checks++; if (new_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL flush_new_pc got=%h exp=bfc00380", new_pc); end
      checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL flush_busy got=%b exp=1", ctrl_busy); end
      tick();
      except_valid = 1'b0;
      #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL hold_flush got=%b exp=0", flush); end
      checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL hold_new_pc got=%h exp=0", new_pc); end
      checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL hold_busy got=%b exp=1", ctrl_busy); end
      tick();
      checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", ctrl_busy); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL idle_flush got=%b exp=0", flush); end
      $display("test_flush done");
   endtask

   task automatic test_dcache_defer();
      tick();
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      except_valid = 1'b1; except_target = 32'h8000_0180;
      set_req(0, 0, 0, 1);
      #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL defer_c0_flush got=%b exp=0", flush); end
      for (int i = 1; i < 5; i++) begin
         tick();
         except_valid  = (i == 2);
         except_target = (i == 2) ? 32'hDEAD_BEEF : 32'h8000_0180;
         #1;
         checks++; if (flush !== 1'b0) begin errors++; $display("FAIL defer_c%0d_flush got=%b exp=0", i, flush); end
         checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL defer_c%0d_busy got=%b exp=1", i, ctrl_busy); end
         checks++; if (stall !== 10'h1FF) begin errors++; $display("FAIL defer_c%0d_stall got=%h exp=1ff", i, stall); end
      end
      tick();
      except_valid = 1'b0;
      set_req(0, 0, 0, 0);
      #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL defer_drop_flush got=%b exp=0", flush); end
      tick();
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL defer_flush got=%b exp=1", flush); end
      checks++; if (new_pc !== 32'h8000_0180) begin errors++; $display("FAIL defer_new_pc got=%h exp=80000180", new_pc); end
      checks++; if (cnt_dcache !== 4'd5) begin errors++; $display("FAIL defer_cnt_dcache got=%0d exp=5", cnt_dcache); end
      repeat (2) tick();
      $display("test_dcache_defer done");
   endtask

   task automatic test_flush_override();
      tick();
      except_valid = 1'b1; except_target = 32'h0000_1000;
      set_req(0, 0, 1, 0);
      #1;
      checks++; if (stall !== 10'h01F) begin errors++; $display("FAIL ovr_pre_stall got=%h exp=01f", stall); end
      tick();
      except_valid = 1'b0;
      #1;
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL ovr_flush got=%b exp=1", flush); end
      checks++; if (stall !== 10'h000) begin errors++; $display("FAIL ovr_stall got=%h exp=000", stall); end
      tick();
      checks++; if (stall !== 10'h01F) begin errors++; $display("FAIL ovr_hold_stall got=%h exp=01f", stall); end
      checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL ovr_hold_busy got=%b exp=1", ctrl_busy); end
      set_req(0, 0, 0, 0);
      tick();
      checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL ovr_idle_busy got=%b exp=0", ctrl_busy); end
      $display("test_flush_override done");
   endtask

   task automatic test_saturate();
      tick();
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      set_req(0, 0, 1, 0);
      repeat (14) tick();
      checks++; if (cnt_ex !== 4'd14) begin errors++; $display("FAIL sat_pre got=%0d exp=14", cnt_ex); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (cnt_ex !== 4'd15) begin errors++; $display("FAIL sat_hold%0d got=%0d exp=15", i, cnt_ex); end
      end
      perf_clr = 1'b1;
      tick();
      checks++; if (cnt_ex !== 4'd0) begin errors++; $display("FAIL sat_clr got=%0d exp=0", cnt_ex); end
      perf_clr = 1'b0;
      set_req(0, 0, 0, 0);
      tick();
      checks++; if (cnt_ex !== 4'd0) begin errors++; $display("FAIL sat_after_clr got=%0d exp=0", cnt_ex); end
      $display("test_saturate done");
   endtask

   task automatic test_reset_mid();
      tick();
      except_valid = 1'b1; except_target = 32'hA000_0000;
      set_req(0, 0, 0, 1);
      tick();
      except_valid = 1'b0;
      #1;
      checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL mid_wait_busy got=%b exp=1", ctrl_busy); end
      tick();
      rst = 1'b1;
      set_req(0, 0, 0, 0);
      tick();
      rst = 1'b0;
      #1;
      checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", ctrl_busy); end
      checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL mid_new_pc got=%h exp=0", new_pc); end
      checks++; if ({cnt_icache, cnt_load, cnt_ex, cnt_dcache} !== 16'h0) begin errors++; $display("FAIL mid_cnts got=%h exp=0000", {cnt_icache, cnt_load, cnt_ex, cnt_dcache}); end
      for (int i = 0; i < 6; i++) begin
         checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mid_noflush%0d got=%b exp=0", i, flush); end
         tick();
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_stall_patterns();
      test_flush();
      test_dcache_defer();
      test_flush_override();
      test_saturate();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 10-stage single-issue pipeline (pc, if, ic, id, ex, dtlb, dt, dcache, mem, wb). It collects stall requests from the icache, the id-stage load-use interlock (bypass network), the ex-stage multi-cycle unit and the dcache. It produces the per-stage stall vector consumed by every pipeline register and the bypass network. It also sequences exception/eret redirects into a one-cycle flush, deferring the flush while a dcache access is outstanding, and keeps saturating stall-cause counters.

Parameters:
CNT_W, 32, width of each stall-cause counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stallreq_icache  in  1  icache miss, stops stages 0..2
stallreq_for_load  in  1  load-use interlock from id, stops stages 0..3
stallreq_for_ex  in  1  multi-cycle ex op busy, stops stages 0..4
stallreq_dcache  in  1  dcache miss/uncached access, stops stages 0..8
except_valid  in  1  exception or eret committed at mem stage
except_target  in  32  redirect pc (vector or epc), valid with except_valid
perf_clr  in  1  synchronous clear of all counters
stall  out  10  per-stage stop (bit k = stage k), `Stop = 1
flush  out  1  one-cycle pipeline flush pulse
new_pc  out  32  redirect pc, valid while flush = 1
ctrl_busy  out  1  exception pending (state != IDLE)
cnt_icache  out  CNT_W  cycles where icache was the winning cause
cnt_load  out  CNT_W  cycles where load-use was the winning cause
cnt_ex  out  CNT_W  cycles where ex was the winning cause
cnt_dcache  out  CNT_W  cycles where dcache was the winning cause

Behaviour:
- Stall vector is combinational from the requests. The deepest active requester wins: dcache -> 10'h1FF; else ex -> 10'h01F; else load -> 10'h00F; else icache -> 10'h007; else 10'h000.
- stall[9] (wb) is never asserted.
- Every asserted pattern is contiguous from bit 0. The stage just above the top set bit receives a bubble, e.g. load-use gives stall[3]=1, stall[4]=0.
- FSM states are IDLE, WAIT_DC, FLUSH and HOLD. All are registered and reset to IDLE.
- IDLE:
  - except_valid with stallreq_dcache = 0 -> FLUSH.
  - except_valid with stallreq_dcache = 1 -> WAIT_DC.
  - In both cases except_target is latched into pend_pc.
- WAIT_DC: stay while stallreq_dcache = 1. The first cycle it is 0 -> FLUSH.
- FLUSH: lasts exactly one cycle, then -> HOLD.
- HOLD: lasts exactly one cycle (squashes a stale except_valid from the instruction behind), then -> IDLE.
- except_valid is ignored in every state except IDLE. pend_pc is never overwritten outside IDLE.
- Flush timing: flush = 1 only in FLUSH. It rises exactly one cycle after the accepting except_valid when there is no dcache stall.
- new_pc = pend_pc in FLUSH, otherwise 0.
- Flush overrides stall: in FLUSH the stall output is forced to 10'h000 regardless of requests.
- ctrl_busy = (state != IDLE).
- Counters:
  - Increment only in IDLE or WAIT_DC, for the single winning cause of that cycle.
  - Saturate at all-ones; no wrap.
  - perf_clr has priority over increment: the counter goes to 0 that cycle and does not increment.
- Reset values: state IDLE, pend_pc 0, flush 0, new_pc 0, ctrl_busy 0, all counters 0. With no requests asserted, stall = 0.
- Reset mid-operation (in WAIT_DC or FLUSH) drops the pending redirect: no flush pulse follows reset.
- Simultaneous except_valid and stallreq_dcache going low in IDLE: the sampled stallreq_dcache of that cycle decides the next state, so a low value goes to FLUSH.
- Simultaneous requests never OR partial patterns; only the winning pattern is driven.

Test Plan:
- Requests: load only -> stall = 10'h00F. Load + icache -> 10'h00F. Ex + load -> 10'h01F. Dcache + all -> 10'h1FF. None -> 10'h000. cnt_load increments once per load-only cycle.
- except_valid = 1 with except_target = 32'hBFC0_0380 and no dcache stall at cycle N -> flush = 1 and new_pc = 32'hBFC0_0380 at N+1 only; ctrl_busy high for N+1..N+2; a second except_valid at N+1 is ignored.
- except_valid with target 32'h8000_0180 while stallreq_dcache is held for 5 cycles -> no flush for 5 cycles. Flush = 1 in the cycle after stallreq_dcache drops, with new_pc = 32'h8000_0180. cnt_dcache = 5.
- In FLUSH with stallreq_for_ex = 1 -> stall = 10'h000 that cycle. stall = 10'h01F resumes in HOLD.
- Force cnt_ex to all-ones-1 and hold ex stall for 3 cycles -> cnt_ex = all-ones and stays. perf_clr together with ex stall -> cnt_ex = 0 next cycle.
- Assert rst while in WAIT_DC -> next cycle state IDLE and flush = 0 forever after. new_pc = 0 and all counters = 0.
